// File: rtl/bonus_slot_scheduler.sv
// Queues bonus-spawn codes and launches at most one per frame into the lowest free slot; SOF -> activate in 1 cycle, busy bit 1 cycle later.
// Backpressure: reqReady drops when the 4-deep queue is full and no pop is under way; nonzero codes offered while full are dropped and flagged in overflow.
module bonus_slot_scheduler #(
  parameter int NUM_SLOTS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               startOfFrame,
  input  logic                               reqValid,
  input  logic [CODE_W-1:0]                  reqCode,
  output logic                               reqReady,
  input  logic [NUM_SLOTS-1:0]               slotDone,
  input  logic                               clearAll,
  output logic [NUM_SLOTS-1:0]               activate,
  output logic [CODE_W-1:0]                  launchCode,
  output logic [NUM_SLOTS-1:0]               slotBusy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    pendingCount,
  output logic                               overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, LAUNCH} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CODE_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [NUM_SLOTS-1:0] activate_q;
  logic [CODE_W-1:0]    code_q;
  logic                 abort;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 launch;
  logic                 any_free;
  logic [IDX_W-1:0]     free_idx;
  logic [CNT_W-1:0]     count_nxt;
  logic [NUM_SLOTS-1:0] busy_nxt;

  assign abort     = reset || clearAll;
  assign pop       = (state == LAUNCH) && !abort;
  assign reqReady  = (pendingCount < DEPTH_C) || pop;
  assign push      = reqValid && (reqCode != '0) && reqReady && !abort;
  assign drop      = reqValid && (reqCode != '0) && !reqReady;
  assign any_free  = ~&slotBusy;
  assign launch    = (state == ARMED) && startOfFrame && any_free && !abort;
  assign count_nxt = pendingCount + CNT_W'(push) - CNT_W'(pop);
  // The slot being set was free when chosen, so set and clear never meet on one bit.
  assign busy_nxt  = (slotBusy & ~slotDone) | (pop ? activate_q : '0);

  // The launch pulse is registered, but a restart in the launch cycle must still kill it.
  assign activate   = abort ? '0 : activate_q;
  assign launchCode = abort ? '0 : code_q;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slotBusy[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pendingCount != '0) state_nxt = ARMED;
      ARMED:   if (launch) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = (count_nxt != '0) ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clearAll) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= reqCode;
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pendingCount <= '0;
      slotBusy     <= '0;
      overflow     <= 1'b0;
      activate_q   <= '0;
      code_q       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      pendingCount <= count_nxt;
      slotBusy     <= busy_nxt;
      if (drop) overflow <= 1'b1;
      activate_q <= launch ? (NUM_SLOTS'(1) << free_idx) : '0;
      code_q     <= launch ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: tb/tb_bonus_slot_scheduler.sv
// Directed bench for bonus_slot_scheduler: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bonus_slot_scheduler;

  logic        clk;
  logic        reset;
  logic        startOfFrame;
  logic        reqValid;
  logic [2:0]  reqCode;
  logic        reqReady;
  logic [15:0] slotDone;
  logic        clearAll;
  logic [15:0] activate;
  logic [2:0]  launchCode;
  logic [15:0] slotBusy;
  logic [2:0]  pendingCount;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] t5_codes [4];

  bonus_slot_scheduler #(.NUM_SLOTS(16), .FIFO_DEPTH(4), .CODE_W(3)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .reqValid(reqValid), .reqCode(reqCode), .reqReady(reqReady),
    .slotDone(slotDone), .clearAll(clearAll), .activate(activate),
    .launchCode(launchCode), .slotBusy(slotBusy),
    .pendingCount(pendingCount), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] code);
    reqValid = 1'b1;
    reqCode  = code;
    tick();
    reqValid = 1'b0;
    reqCode  = 3'd0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    t5_codes = '{3'd2, 3'd3, 3'd4, 3'd6};
    reset = 1'b1; startOfFrame = 1'b0; reqValid = 1'b0; reqCode = 3'd0;
    slotDone = 16'h0; clearAll = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_activate", activate, 0);
    check("rst_code", launchCode, 0);
    check("rst_busy", slotBusy, 0);
    check("rst_count", pendingCount, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ready", reqReady, 1);

    // Basic launch
    push(3'd3);
    check("t1_count_push", pendingCount, 1);
    tick();
    sof();
    check("t1_activate", activate, 16'h0001);
    check("t1_code", launchCode, 3);
    check("t1_busy_lag", slotBusy, 0);
    check("t1_count_hold", pendingCount, 1);
    tick();
    check("t1_activate_off", activate, 0);
    check("t1_code_off", launchCode, 0);
    check("t1_busy", slotBusy, 16'h0001);
    check("t1_count_pop", pendingCount, 0);
    sof();
    check("t1_idle_sof", activate, 0);
    tick();

    // Order and one launch per frame
    clearAll = 1'b1; tick(); clearAll = 1'b0;
    check("t2_clear_busy", slotBusy, 0);
    push(3'd1); push(3'd2); push(3'd5);
    check("t2_count3", pendingCount, 3);
    startOfFrame = 1'b1;
    tick();
    check("t2_act0", activate, 16'h0001);
    check("t2_code0", launchCode, 1);
    tick();
    startOfFrame = 1'b0;
    check("t2_sof_in_launch", activate, 0);
    check("t2_count2", pendingCount, 2);
    sof();
    check("t2_act1", activate, 16'h0002);
    check("t2_code1", launchCode, 2);
    tick();
    check("t2_busy3", slotBusy, 16'h0003);
    sof();
    check("t2_act2", activate, 16'h0004);
    check("t2_code2", launchCode, 5);
    tick();
    check("t2_busy7", slotBusy, 16'h0007);
    check("t2_count0", pendingCount, 0);

    // Overflow
    push(3'd1); push(3'd2); push(3'd3); push(3'd4);
    check("t4_ready_full", reqReady, 0);
    check("t4_count_full", pendingCount, 4);
    check("t4_ovf_before", overflow, 0);
    push(3'd0);
    check("t4_zero_no_ovf", overflow, 0);
    push(3'd6);
    check("t4_ovf_set", overflow, 1);
    check("t4_count_capped", pendingCount, 4);

    // Push and pop in the same cycle while full
    sof();
    check("t5_act_first", activate, 16'h0008);
    check("t5_code_first", launchCode, 1);
    check("t5_ready_pop", reqReady, 1);
    push(3'd6);
    check("t5_count_same", pendingCount, 4);
    check("t5_busy", slotBusy, 16'h000F);
    for (int k = 0; k < 4; k++) begin
      sof();
      check("t5_act", activate, 32'h10 << k);
      check("t5_code", launchCode, t5_codes[k]);
      tick();
    end
    check("t5_count_end", pendingCount, 0);
    check("t5_busy_end", slotBusy, 16'h00FF);
    check("t5_ovf_sticky", overflow, 1);

    // All slots busy
    for (int k = 0; k < 8; k++) begin
      push(3'd7);
      tick();
      sof();
      check("t3_fill_act", activate, 32'h100 << k);
      tick();
    end
    check("t3_all_busy", slotBusy, 16'hFFFF);
    push(3'd4);
    tick();
    sof();
    check("t3_no_free", activate, 0);
    check("t3_kept", pendingCount, 1);
    startOfFrame = 1'b1;
    slotDone = 16'h0200;
    tick();
    startOfFrame = 1'b0;
    slotDone = 16'h0;
    check("t3_freed_same_sof", activate, 0);
    check("t3_busy_freed", slotBusy, 16'hFDFF);
    sof();
    check("t3_act9", activate, 16'h0200);
    check("t3_code9", launchCode, 4);
    tick();
    check("t3_busy_full", slotBusy, 16'hFFFF);

    // Reset mid-operation
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_busy", slotBusy, 0);
    check("rst2_ovf", overflow, 0);
    check("rst2_ready", reqReady, 1);

    // clearAll coincident with a launch
    push(3'd1); push(3'd2);
    sof(); tick(); sof(); tick();
    check("t6_busy3", slotBusy, 16'h0003);
    push(3'd3); push(3'd4); push(3'd5); push(3'd6); push(3'd7);
    check("t6_ovf", overflow, 1);
    check("t6_count", pendingCount, 4);
    sof();
    clearAll = 1'b1;
    #1;
    check("t6_pulse_killed", activate, 0);
    check("t6_code_killed", launchCode, 0);
    tick();
    clearAll = 1'b0;
    check("t6_busy_clr", slotBusy, 0);
    check("t6_count_clr", pendingCount, 0);
    check("t6_ovf_clr", overflow, 0);
    check("t6_act_after", activate, 0);
    sof();
    check("t6_sof_nothing", activate, 0);
    tick();
    check("t6_busy_still", slotBusy, 0);
    clearAll = 1'b1;
    reqValid = 1'b1;
    reqCode = 3'd2;
    tick();
    clearAll = 1'b0;
    reqValid = 1'b0;
    reqCode = 3'd0;
    check("t6_push_discard", pendingCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
